end_screen_switch: RTL and testbench
====================================

# end_screen_switch

Frame-synchronous source switch between the game-play VGA pipeline and the game-over pipeline (end_Vga_sync / end_Vga_control / ex5_over_rom), placed directly downstream of both, driving the board VGA pins. On a game-over request it waits for a frame boundary and hands the screen to the end image. It blinks the end image a programmable number of times, pulses Flash_over_sig, then holds the image until a restart request returns control, again on a frame boundary.

## Interface
- BLINK_FRAMES, 30: frames per blink half-period (on or off); legal ≥1
- BLINK_COUNT, 3: number of off-phases before steady display; legal ≥1
- VS_ACTIVE, 1'b1: active level of vertical sync (both sources)
- HS_ACTIVE, 1'b1: active level of horizontal sync (both sources)

- CLK_40M  in  1  pixel clock, 40 MHz (800x600@60)
- RST  in  1  asynchronous, active-high reset
- Over_sig  in  1  game-over request, level or pulse, sampled each cycle
- Restart_sig  in  1  restart request, single-cycle pulse
- game_Vga_red / game_Vga_green / game_Vga_blue  in  1 each  game-pipeline colour
- game_Hsync_sig / game_Vsync_sig  in  1 each  game-pipeline syncs
- end_Vga_red / end_Vga_green / end_Vga_blue  in  1 each  end-pipeline colour
- end_Hsync_sig / end_Vsync_sig  in  1 each  end-pipeline syncs
- Vga_red / Vga_green / Vga_blue  out  1 each  pin colour, registered
- Hsync_sig / Vsync_sig  out  1 each  pin syncs, registered
- Show_end  out  1  high while the end source is selected
- Flash_over_sig  out  1  one-cycle pulse when blinking completes

## Operation
- Both pipelines run free on CLK_40M with aligned timing. This block only selects between them and never regenerates timing.
- Frame edge: a source's Vsync sample equals VS_ACTIVE and the previous sample does not. One detector runs per source.
- States:
  - PLAY: selects game. If Over_sig=1, go to ARM_END. Over_sig wins over a simultaneous Restart_sig.
  - ARM_END: selects game. On a game frame edge, go to END_BLINK with frame_cnt=0, off_cnt=0, phase=visible. Restart_sig is ignored.
  - END_BLINK: selects end. Count end frame edges. When frame_cnt reaches BLINK_FRAMES-1 on an edge, clear it and toggle phase. off_cnt increments on each off→visible toggle. On the toggle that makes off_cnt = BLINK_COUNT, go to END_HOLD and pulse Flash_over_sig for that cycle. Restart_sig goes to ARM_PLAY with no Flash_over_sig pulse.
  - END_HOLD: selects end, steady visible. Restart_sig goes to ARM_PLAY. Over_sig is ignored.
  - ARM_PLAY: selects end, phase forced visible. On an end frame edge, go to PLAY. Over_sig is ignored.
- Off phase: RGB is forced to 0. Syncs still come from the end source.
- Show_end = 1 in END_BLINK, END_HOLD and ARM_PLAY.
- Counter widths are $clog2 of their parameter +1. Counters never wrap inside a state.

## Timing
- Reset values:
  - state = PLAY.
  - Vga_red / Vga_green / Vga_blue = 0.
  - Hsync_sig = ~HS_ACTIVE, Vsync_sig = ~VS_ACTIVE.
  - Show_end = 0, Flash_over_sig = 0, all counters 0.
- Pixel path latency: exactly 1 clock, from input sample to the pin register, for all five signals.
- Switching: the edge is detected in cycle t and the state updates at the end of t. The new source appears on the pins from the sample taken in cycle t+1.
- The first frame edge after entering ARM_END or ARM_PLAY counts, even if it occurs in the cycle of entry+1.
- Flash_over_sig is high for exactly 1 cycle, coincident with the first cycle of END_HOLD on Show_end.
- RST asserted mid-frame or mid-blink: immediate return to reset values. Game source is shown from the first cycle after deassertion. No glitch suppression is required.

## Structure
- Shared package end_screen_pkg holds:
  - the state enum (PLAY, ARM_END, END_BLINK, END_HOLD, ARM_PLAY);
  - the default BLINK_FRAMES / BLINK_COUNT constants;
  - the 800x600@40 MHz timing constants (H_TOTAL 1056, V_TOTAL 628) for bench use.
- One sub-module, vs_edge_det: a registered previous-sample detector, parameter VS_ACTIVE, instantiated twice (game and end).
- The FSM, counters and output mux live in the top module.

## Test plan
All scenarios use BLINK_FRAMES=2, BLINK_COUNT=2 and a bench timing generator with a 20-cycle frame.

1. Reset → pins show the game source, delayed 1 cycle. Show_end=0, Hsync_sig/Vsync_sig inactive while RST=1.
2. Over_sig pulse at mid-frame → pins stay on game until the next game Vsync edge, then switch to end on the following sample. Show_end rises in the same cycle.
3. Blink sequence → pattern is 2 frames visible, 2 off (RGB=0, syncs toggling), 2 visible, 2 off, then visible. Flash_over_sig fires once, 8 end-frame edges after entry.
4. Restart_sig in END_HOLD → end image stays until the next end Vsync edge, then game. Show_end falls, and no second Flash_over_sig occurs.
5. Restart_sig during the second off phase → goes to ARM_PLAY, RGB is visible immediately, returns to game at the next frame edge, and Flash_over_sig never pulses.
6. Simultaneous Over_sig and Restart_sig in PLAY → goes to ARM_END. RST asserted in END_BLINK → outputs at reset values asynchronously, then game shown after release.

Source files
------------

// File: rtl/end_screen_pkg.sv
// Shared types and constants for the game/end screen source switch.
package end_screen_pkg;

  // Screen-ownership states of the switch
  typedef enum logic [2:0] {
    PLAY      = 3'd0,
    ARM_END   = 3'd1,
    END_BLINK = 3'd2,
    END_HOLD  = 3'd3,
    ARM_PLAY  = 3'd4
  } state_t;

  // Default blink behaviour: 30 frames per half-period, 3 off-phases
  localparam int DEF_BLINK_FRAMES = 30;
  localparam int DEF_BLINK_COUNT  = 3;

  // 800x600 @ 40 MHz pixel clock frame geometry
  localparam int H_TOTAL = 1056;
  localparam int V_TOTAL = 628;

endpackage

// File: rtl/end_screen_switch_vs_edge_det.sv
// Frame-start detector: flags the cycle where vsync turns active.
module vs_edge_det #(
  parameter logic VS_ACTIVE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic vs,
  output logic frame_edge
);

  logic prev_vs;

  // Remember the previous vsync sample; reset to the inactive level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_vs <= ~VS_ACTIVE;
    end else begin
      prev_vs <= vs;
    end
  end

  // Edge is combinational so the FSM can act in the same cycle
  assign frame_edge = (vs == VS_ACTIVE) && (prev_vs != VS_ACTIVE);

endmodule

// File: rtl/end_screen_switch.sv
// Frame-synchronous switch between the game-play and game-over VGA sources,
// including the end-image blink sequence and registered pin outputs.
module end_screen_switch
  import end_screen_pkg::*;
#(
  parameter int   BLINK_FRAMES = DEF_BLINK_FRAMES,
  parameter int   BLINK_COUNT  = DEF_BLINK_COUNT,
  parameter logic VS_ACTIVE    = 1'b1,
  parameter logic HS_ACTIVE    = 1'b1
) (
  input  logic CLK_40M,
  input  logic RST,
  input  logic Over_sig,
  input  logic Restart_sig,
  input  logic game_Vga_red,
  input  logic game_Vga_green,
  input  logic game_Vga_blue,
  input  logic game_Hsync_sig,
  input  logic game_Vsync_sig,
  input  logic end_Vga_red,
  input  logic end_Vga_green,
  input  logic end_Vga_blue,
  input  logic end_Hsync_sig,
  input  logic end_Vsync_sig,
  output logic Vga_red,
  output logic Vga_green,
  output logic Vga_blue,
  output logic Hsync_sig,
  output logic Vsync_sig,
  output logic Show_end,
  output logic Flash_over_sig
);

  localparam int FW = $clog2(BLINK_FRAMES) + 1;
  localparam int CW = $clog2(BLINK_COUNT) + 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(BLINK_COUNT - 1);

  state_t          state;
  logic [FW-1:0]   frame_cnt;
  logic [CW-1:0]   off_cnt;
  logic            phase_off;
  logic            game_edge;
  logic            end_edge;
  logic            blank;
  logic [2:0]      mux_rgb;
  logic            mux_hs;
  logic            mux_vs;

  vs_edge_det #(.VS_ACTIVE(VS_ACTIVE)) u_game_edge (
    .clk        (CLK_40M),
    .rst        (RST),
    .vs         (game_Vsync_sig),
    .frame_edge (game_edge)
  );

  vs_edge_det #(.VS_ACTIVE(VS_ACTIVE)) u_end_edge (
    .clk        (CLK_40M),
    .rst        (RST),
    .vs         (end_Vsync_sig),
    .frame_edge (end_edge)
  );

  // Screen-ownership FSM with blink counters and registered status outputs
  always_ff @(posedge CLK_40M or posedge RST) begin
    if (RST) begin
      state          <= PLAY;
      frame_cnt      <= {FW{1'b0}};
      off_cnt        <= {CW{1'b0}};
      phase_off      <= 1'b0;
      Show_end       <= 1'b0;
      Flash_over_sig <= 1'b0;
    end else begin
      Flash_over_sig <= 1'b0;
      case (state)
        PLAY: begin
          // Over_sig alone decides; a coincident restart is meaningless here
          if (Over_sig) begin
            state <= ARM_END;
          end
        end
        ARM_END: begin
          if (game_edge) begin
            state     <= END_BLINK;
            frame_cnt <= {FW{1'b0}};
            off_cnt   <= {CW{1'b0}};
            phase_off <= 1'b0;
            Show_end  <= 1'b1;
          end
        end
        END_BLINK: begin
          if (Restart_sig) begin
            state     <= ARM_PLAY;
            frame_cnt <= {FW{1'b0}};
            off_cnt   <= {CW{1'b0}};
            phase_off <= 1'b0;
          end else if (end_edge) begin
            if (frame_cnt == FRAME_LAST) begin
              frame_cnt <= {FW{1'b0}};
              if (phase_off) begin
                // Off -> visible completes one blink
                phase_off <= 1'b0;
                off_cnt   <= off_cnt + {{(CW-1){1'b0}}, 1'b1};
                if (off_cnt == COUNT_LAST) begin
                  state          <= END_HOLD;
                  Flash_over_sig <= 1'b1;
                end
              end else begin
                phase_off <= 1'b1;
              end
            end else begin
              frame_cnt <= frame_cnt + {{(FW-1){1'b0}}, 1'b1};
            end
          end
        end
        END_HOLD: begin
          if (Restart_sig) begin
            state <= ARM_PLAY;
          end
        end
        ARM_PLAY: begin
          phase_off <= 1'b0;
          if (end_edge) begin
            state    <= PLAY;
            Show_end <= 1'b0;
          end
        end
        default: begin
          state     <= PLAY;
          frame_cnt <= {FW{1'b0}};
          off_cnt   <= {CW{1'b0}};
          phase_off <= 1'b0;
          Show_end  <= 1'b0;
        end
      endcase
    end
  end

  // Blanking only applies during the off half of a blink
  assign blank = (state == END_BLINK) && phase_off;

  // Source select; Show_end mirrors the end-owning states exactly
  always_comb begin
    mux_rgb = 3'b000;
    mux_hs  = game_Hsync_sig;
    mux_vs  = game_Vsync_sig;
    if (Show_end) begin
      mux_hs = end_Hsync_sig;
      mux_vs = end_Vsync_sig;
      if (blank) begin
        mux_rgb = 3'b000;
      end else begin
        mux_rgb = {end_Vga_red, end_Vga_green, end_Vga_blue};
      end
    end else begin
      mux_rgb = {game_Vga_red, game_Vga_green, game_Vga_blue};
    end
  end

  // Pin register: one clock of latency for colour and syncs alike
  always_ff @(posedge CLK_40M or posedge RST) begin
    if (RST) begin
      Vga_red   <= 1'b0;
      Vga_green <= 1'b0;
      Vga_blue  <= 1'b0;
      Hsync_sig <= ~HS_ACTIVE;
      Vsync_sig <= ~VS_ACTIVE;
    end else begin
      {Vga_red, Vga_green, Vga_blue} <= mux_rgb;
      Hsync_sig <= mux_hs;
      Vsync_sig <= mux_vs;
    end
  end

endmodule

// File: tb/tb_end_screen_switch.sv
// Directed bench for end_screen_switch with a 20-cycle synthetic frame.
module tb_end_screen_switch;

  logic CLK_40M = 1'b0;
  logic RST = 1'b1;
  logic Over_sig = 1'b0;
  logic Restart_sig = 1'b0;
  logic game_Vga_red, game_Vga_green, game_Vga_blue, game_Hsync_sig, game_Vsync_sig;
  logic end_Vga_red, end_Vga_green, end_Vga_blue, end_Hsync_sig, end_Vsync_sig;
  logic Vga_red, Vga_green, Vga_blue, Hsync_sig, Vsync_sig, Show_end, Flash_over_sig;

  int errors = 0;
  int checks = 0;
  int seg = 0;
  int flashes = 0;
  logic [4:0] cnt = 5'd0;
  logic [4:0] prev_cnt = 5'd0;
  logic cur_sel = 1'b0, cur_blank = 1'b0, prev_sel = 1'b0, prev_blank = 1'b0;
  logic exp_flash;
  logic back;
  logic [4:0] pins;

  always #5 CLK_40M = ~CLK_40M;

  // Free-running frame counter: 20 cycles per frame, vsync edge at cnt 0
  always @(posedge CLK_40M) cnt <= (cnt == 5'd19) ? 5'd0 : cnt + 5'd1;

  assign {game_Vga_red, game_Vga_green, game_Vga_blue} = cnt[2:0];
  assign {end_Vga_red, end_Vga_green, end_Vga_blue} = ~cnt[2:0];
  assign game_Hsync_sig = (cnt % 5'd5) == 5'd0;
  assign end_Hsync_sig  = (cnt % 5'd5) == 5'd2;
  assign game_Vsync_sig = cnt < 5'd2;
  assign end_Vsync_sig  = cnt < 5'd3;
  assign pins = {Vga_red, Vga_green, Vga_blue, Hsync_sig, Vsync_sig};

  end_screen_switch #(
    .BLINK_FRAMES(2), .BLINK_COUNT(2), .VS_ACTIVE(1'b1), .HS_ACTIVE(1'b1)
  ) dut (
    .CLK_40M(CLK_40M), .RST(RST), .Over_sig(Over_sig), .Restart_sig(Restart_sig),
    .game_Vga_red(game_Vga_red), .game_Vga_green(game_Vga_green), .game_Vga_blue(game_Vga_blue),
    .game_Hsync_sig(game_Hsync_sig), .game_Vsync_sig(game_Vsync_sig),
    .end_Vga_red(end_Vga_red), .end_Vga_green(end_Vga_green), .end_Vga_blue(end_Vga_blue),
    .end_Hsync_sig(end_Hsync_sig), .end_Vsync_sig(end_Vsync_sig),
    .Vga_red(Vga_red), .Vga_green(Vga_green), .Vga_blue(Vga_blue),
    .Hsync_sig(Hsync_sig), .Vsync_sig(Vsync_sig),
    .Show_end(Show_end), .Flash_over_sig(Flash_over_sig)
  );

  // Expected pins given the source chosen in the sampled cycle
  function automatic logic [4:0] exp_pins(input logic sel, input logic blank, input logic [4:0] c);
    logic [2:0] rgb;
    if (!sel) return {c[2:0], (c % 5'd5) == 5'd0, c < 5'd2};
    rgb = blank ? 3'b000 : ~c[2:0];
    return {rgb, (c % 5'd5) == 5'd2, c < 5'd3};
  endfunction

  // Advance one clock; remember what the pins should now be showing
  task automatic tick();
    prev_cnt = cnt;
    prev_sel = cur_sel;
    prev_blank = cur_blank;
    @(posedge CLK_40M);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) begin
      tick();
      checks++; if (pins !== 5'b00000) begin errors++; $display("FAIL reset_pins got=%b exp=00000", pins); end
      checks++; if (Show_end !== 1'b0 || Flash_over_sig !== 1'b0) begin errors++; $display("FAIL reset_status got=%b%b exp=00", Show_end, Flash_over_sig); end
    end
    RST = 1'b0;
    cur_sel = 1'b0; cur_blank = 1'b0;
    repeat (4) begin
      tick();
      checks++; if (pins !== exp_pins(prev_sel, prev_blank, prev_cnt)) begin errors++; $display("FAIL release_pins got=%b exp=%b", pins, exp_pins(prev_sel, prev_blank, prev_cnt)); end
      checks++; if (Show_end !== 1'b0) begin errors++; $display("FAIL release_show got=%b exp=0", Show_end); end
    end
  endtask

  task automatic test_over_switch();
    while (cnt != 5'd10) tick();
    Over_sig = 1'b1; tick(); Over_sig = 1'b0;
    checks++; if (pins !== exp_pins(prev_sel, prev_blank, prev_cnt) || Show_end !== 1'b0) begin errors++; $display("FAIL over_arm got=%b/%b exp=%b/0", pins, Show_end, exp_pins(prev_sel, prev_blank, prev_cnt)); end
    do begin
      tick();
      if (cnt == 5'd1) cur_sel = 1'b1;
      checks++; if (pins !== exp_pins(prev_sel, prev_blank, prev_cnt)) begin errors++; $display("FAIL over_pins cnt=%0d got=%b exp=%b", prev_cnt, pins, exp_pins(prev_sel, prev_blank, prev_cnt)); end
      checks++; if (Show_end !== cur_sel) begin errors++; $display("FAIL over_show cnt=%0d got=%b exp=%b", cnt, Show_end, cur_sel); end
    end while (cnt != 5'd1);
  endtask

  task automatic test_blink();
    seg = 0; flashes = 0;
    do begin
      tick();
      if (cnt == 5'd1) seg++;
      cur_blank = (seg == 2) || (seg == 3) || (seg == 6) || (seg == 7);
      exp_flash = (seg == 8) && (cnt == 5'd1);
      if (Flash_over_sig === 1'b1) flashes++;
      checks++; if (pins !== exp_pins(prev_sel, prev_blank, prev_cnt)) begin errors++; $display("FAIL blink_pins seg=%0d got=%b exp=%b", seg, pins, exp_pins(prev_sel, prev_blank, prev_cnt)); end
      checks++; if (Show_end !== 1'b1) begin errors++; $display("FAIL blink_show seg=%0d got=%b exp=1", seg, Show_end); end
      checks++; if (Flash_over_sig !== exp_flash) begin errors++; $display("FAIL blink_flash seg=%0d cnt=%0d got=%b exp=%b", seg, cnt, Flash_over_sig, exp_flash); end
    end while (!((seg == 8) && (cnt == 5'd5)));
    checks++; if (flashes != 1) begin errors++; $display("FAIL flash_count got=%0d exp=1", flashes); end
  endtask

  task automatic test_restart_hold();
    Restart_sig = 1'b1; tick(); Restart_sig = 1'b0;
    back = 1'b0;
    do begin
      tick();
      if (cnt == 5'd1) begin cur_sel = 1'b0; back = 1'b1; end
      checks++; if (pins !== exp_pins(prev_sel, prev_blank, prev_cnt)) begin errors++; $display("FAIL hold_pins cnt=%0d got=%b exp=%b", prev_cnt, pins, exp_pins(prev_sel, prev_blank, prev_cnt)); end
      checks++; if (Show_end !== cur_sel || Flash_over_sig !== 1'b0) begin errors++; $display("FAIL hold_status got=%b%b exp=%b0", Show_end, Flash_over_sig, cur_sel); end
    end while (!(back && (cnt == 5'd4)));
  endtask

  task automatic test_restart_blink();
    while (cnt != 5'd8) tick();
    Over_sig = 1'b1; tick(); Over_sig = 1'b0;
    seg = -1;
    do begin
      tick();
      if (cnt == 5'd1) begin seg++; cur_sel = 1'b1; end
      cur_blank = (seg == 2) || (seg == 3) || (seg == 6) || (seg == 7);
      checks++; if (pins !== exp_pins(prev_sel, prev_blank, prev_cnt)) begin errors++; $display("FAIL rb_pins seg=%0d got=%b exp=%b", seg, pins, exp_pins(prev_sel, prev_blank, prev_cnt)); end
      checks++; if (Show_end !== cur_sel || Flash_over_sig !== 1'b0) begin errors++; $display("FAIL rb_status got=%b%b exp=%b0", Show_end, Flash_over_sig, cur_sel); end
    end while (!((seg == 6) && (cnt == 5'd10)));
    Restart_sig = 1'b1; tick(); Restart_sig = 1'b0;
    cur_blank = 1'b0;
    back = 1'b0;
    do begin
      tick();
      if (cnt == 5'd1) begin cur_sel = 1'b0; back = 1'b1; end
      checks++; if (pins !== exp_pins(prev_sel, prev_blank, prev_cnt)) begin errors++; $display("FAIL rb_ret_pins cnt=%0d got=%b exp=%b", prev_cnt, pins, exp_pins(prev_sel, prev_blank, prev_cnt)); end
      checks++; if (Show_end !== cur_sel || Flash_over_sig !== 1'b0) begin errors++; $display("FAIL rb_ret_status got=%b%b exp=%b0", Show_end, Flash_over_sig, cur_sel); end
    end while (!(back && (cnt == 5'd4)));
  endtask

  task automatic test_simul_and_reset();
    Over_sig = 1'b1; Restart_sig = 1'b1; tick(); Over_sig = 1'b0; Restart_sig = 1'b0;
    seg = -1;
    do begin
      tick();
      if (cnt == 5'd1) begin seg++; cur_sel = 1'b1; end
      cur_blank = (seg == 2) || (seg == 3);
      checks++; if (pins !== exp_pins(prev_sel, prev_blank, prev_cnt)) begin errors++; $display("FAIL sim_pins seg=%0d got=%b exp=%b", seg, pins, exp_pins(prev_sel, prev_blank, prev_cnt)); end
      checks++; if (Show_end !== cur_sel) begin errors++; $display("FAIL sim_show got=%b exp=%b", Show_end, cur_sel); end
    end while (!((seg == 2) && (cnt == 5'd5)));
    RST = 1'b1;
    #2;
    checks++; if (pins !== 5'b00000) begin errors++; $display("FAIL async_rst_pins got=%b exp=00000", pins); end
    checks++; if (Show_end !== 1'b0 || Flash_over_sig !== 1'b0) begin errors++; $display("FAIL async_rst_status got=%b%b exp=00", Show_end, Flash_over_sig); end
    cur_sel = 1'b0; cur_blank = 1'b0;
    tick();
    checks++; if (pins !== 5'b00000) begin errors++; $display("FAIL held_rst_pins got=%b exp=00000", pins); end
    RST = 1'b0;
    repeat (4) begin
      tick();
      checks++; if (pins !== exp_pins(prev_sel, prev_blank, prev_cnt)) begin errors++; $display("FAIL post_rst_pins got=%b exp=%b", pins, exp_pins(prev_sel, prev_blank, prev_cnt)); end
      checks++; if (Show_end !== 1'b0) begin errors++; $display("FAIL post_rst_show got=%b exp=0", Show_end); end
    end
  endtask

  initial begin
    test_reset();
    test_over_switch();
    test_blink();
    test_restart_hold();
    test_restart_blink();
    test_simul_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
